// File: rtl/alu_sin_deserializer.sv
// Serial ALU receive front end: recovers 11-bit frames from sin and
// assembles 8 DATA + 1 CMD frames into {B, A, OP} with error coding.
module alu_sin_deserializer #(
  parameter int         N_DATA_FRAMES = 8,
  parameter logic [3:0] CRC_INIT      = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_A,
  output logic [31:0] out_B,
  output logic [2:0]  out_op,
  output logic [1:0]  out_err,
  output logic        overrun
);

  localparam int CW = $clog2(N_DATA_FRAMES + 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TYPE,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_st;
  logic [2:0]    r_bit;
  logic [7:0]    r_byte;
  logic          r_is_cmd;
  logic          r_wait_hi;
  logic [CW-1:0] r_cnt;
  logic          r_bad;
  logic [63:0]   r_ba;
  logic [3:0]    r_crc;
  logic          r_close;

  logic          w_crc_ok;
  logic          w_dbad;
  logic [2:0]    w_op;
  logic [1:0]    w_err;

  function automatic logic [3:0] crc_step(
    input logic [3:0] c,
    input logic       b
  );
    return {c[2:0], 1'b0} ^ ((c[3] ^ b) ? 4'h3 : 4'h0);
  endfunction

  // CMD byte stays in r_byte for the cycle after its stop bit
  assign w_op     = r_byte[6:4];
  assign w_crc_ok = (r_crc == r_byte[3:0]);
  assign w_dbad   = r_bad || (r_cnt != CW'(N_DATA_FRAMES));

  always_comb begin
    w_err = 2'b00;
    if (w_dbad)
      w_err = 2'b01;
    else if (!w_crc_ok)
      w_err = 2'b10;
    else if (w_op[1])
      w_err = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st      <= S_IDLE;
      r_bit     <= '0;
      r_byte    <= '0;
      r_is_cmd  <= 1'b0;
      r_wait_hi <= 1'b0;
      r_cnt     <= '0;
      r_bad     <= 1'b0;
      r_ba      <= '0;
      r_crc     <= CRC_INIT;
      r_close   <= 1'b0;
      out_valid <= 1'b0;
      out_A     <= '0;
      out_B     <= '0;
      out_op    <= '0;
      out_err   <= '0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (out_valid && out_ready)
        out_valid <= 1'b0;

      if (r_close) begin
        r_close <= 1'b0;
        if (out_valid && !out_ready) begin
          overrun <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_err   <= w_err;
          out_B     <= w_dbad ? 32'h0 : r_ba[63:32];
          out_A     <= w_dbad ? 32'h0 : r_ba[31:0];
          out_op    <= w_dbad ? 3'h0 : w_op;
        end
        r_cnt <= '0;
        r_bad <= 1'b0;
        r_ba  <= '0;
        r_crc <= CRC_INIT;
      end

      unique case (r_st)
        S_IDLE: begin
          if (r_wait_hi) begin
            if (sin)
              r_wait_hi <= 1'b0;
          end else if (!sin) begin
            r_st <= S_TYPE;
          end
        end
        S_TYPE: begin
          r_is_cmd <= sin;
          r_bit    <= '0;
          r_st     <= S_DATA;
          // the constant 1 between {B,A} and OP in the CRC vector
          if (sin)
            r_crc <= crc_step(r_crc, 1'b1);
        end
        S_DATA: begin
          r_byte <= {r_byte[6:0], sin};
          r_bit  <= r_bit + 3'd1;
          if (!r_is_cmd || (r_bit != 3'd0 && r_bit < 3'd4))
            r_crc <= crc_step(r_crc, sin);
          if (r_bit == 3'd7)
            r_st <= S_STOP;
        end
        S_STOP: begin
          r_st <= S_IDLE;
          if (!sin) begin
            r_bad     <= 1'b1;
            r_wait_hi <= 1'b1;
          end else if (r_is_cmd) begin
            r_close <= 1'b1;
          end else begin
            r_ba <= {r_ba[55:0], r_byte};
            if (r_cnt != CW'(N_DATA_FRAMES + 1))
              r_cnt <= r_cnt + CW'(1);
            if (r_cnt >= CW'(N_DATA_FRAMES))
              r_bad <= 1'b1;
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule
